// File: rtl/fb_pkg.sv
// Shared framebuffer types: default geometry, address width, pixel record and
// the write-sequencer state encoding.
package fb_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int FB_ADDR_W = 19;
    localparam int COORD_W   = 11;
    localparam int COLOUR_W  = 4;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        colour_t            colour;
    } pixel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with a registered head word (first-word fall-through).
// A word pushed into an empty FIFO becomes visible at the head one cycle later.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  pixel_t                 push_data,
    input  logic                   pop,
    output pixel_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pixel_t          ram [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   ram_count;
    logic            head_valid;
    logic            wr_en;
    logic            rd_en;
    logic            load;

    // count covers the head register too, so total capacity stays at DEPTH
    assign full      = (count == CW'(DEPTH));
    assign empty     = !head_valid;
    assign level     = count;
    assign wr_en     = push && !full;
    assign rd_en     = pop && head_valid;
    assign ram_count = count - CW'(head_valid);
    assign load      = (ram_count != '0) && (!head_valid || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            count <= count + CW'(wr_en) - CW'(rd_en);
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                head       <= ram[rd_ptr];
                head_valid <= 1'b1;
                rd_ptr     <= rd_ptr + AW'(1);
            end else if (rd_en) begin
                head_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: clips rasterizer pixels, queues them and issues
// acknowledged memory writes in order. Optional macro FB_TRANSPARENT_EN skips colour 0.
//
// state   | meaning
// S_IDLE  | waiting for a queued pixel
// S_ADDR  | computing address/data from the hold register
// S_WRITE | presenting the write until mem_ack
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 request,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [COLOUR_W-1:0]  TRIcolour,
    output logic                 full,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [COLOUR_W-1:0]  mem_data,
    output logic                 mem_we,
    input  logic                 mem_ack,
    output logic [15:0]          dropped,
    output logic                 idle
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);

    state_t                       state;
    pixel_t                       in_pix;
    pixel_t                       hold;
    pixel_t                       fifo_head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic                         clipped;
    logic                         transparent;
    logic                         push;
    logic                         pop;
    logic [FB_ADDR_W-1:0]         x_ext;
    logic [FB_ADDR_W-1:0]         y_ext;
    logic [FB_ADDR_W-1:0]         addr_calc;

`ifdef FB_TRANSPARENT_EN
    assign transparent = (TRIcolour == '0);
`else
    assign transparent = 1'b0;
`endif

    assign in_pix  = '{x: x, y: y, colour: TRIcolour};
    assign clipped = (x >= X_LIM) || (y >= Y_LIM) || transparent;
    assign push    = request && !clipped;
    assign pop     = !fifo_empty &&
                     ((state == S_IDLE) || ((state == S_WRITE) && mem_ack));

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (Reset),
        .push      (push),
        .push_data (in_pix),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign x_ext = FB_ADDR_W'(hold.x);
    assign y_ext = FB_ADDR_W'(hold.y);

    generate
        if (H_RES == 640) begin : g_shift_add
            // 640 = 512 + 128
            assign addr_calc = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_mult
            assign addr_calc = y_ext * FB_ADDR_W'(H_RES) + x_ext;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            hold     <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        hold  <= fifo_head;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    mem_addr <= addr_calc;
                    mem_data <= hold.colour;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        if (!fifo_empty) begin
                            hold  <= fifo_head;
                            state <= S_ADDR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // a pop on the same edge never frees room for an overflowing push
    always_ff @(posedge clk) begin
        if (Reset) begin
            dropped <= '0;
        end else if (push && fifo_full && (dropped != 16'hFFFF)) begin
            dropped <= dropped + 16'd1;
        end
    end

    assign mem_we = (state == S_WRITE);
    assign full   = fifo_full;
    assign idle   = (fifo_level == '0) && (state == S_IDLE);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: scoreboard of expected writes,
// one task per scenario.
module tb_fb_pixel_writer;

    localparam int HR = 640;
    localparam int VR = 480;

    typedef struct {
        logic [18:0] addr;
        logic [3:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        request = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic [3:0]  TRIcolour = '0;
    logic        full;
    logic [18:0] mem_addr;
    logic [3:0]  mem_data;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic [15:0] dropped;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int cycle = 0;
    exp_t exp_q[$];
    int wcycles[$];

    fb_pixel_writer #(
        .H_RES      (HR),
        .V_RES      (VR),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .request   (request),
        .x         (x),
        .y         (y),
        .TRIcolour (TRIcolour),
        .full      (full),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .dropped   (dropped),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // a write is accepted on the next rising edge when we and ack are both high here
    always @(negedge clk) begin
        if (!Reset && mem_we === 1'b1 && mem_ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_data !== e.data) begin
                    errors++;
                    $display("FAIL write_order got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
            writes++;
            wcycles.push_back(cycle);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // present one pixel for one rising edge; queue its write if it should be kept
    task automatic send(input int px, input int py, input int pc, input bit keep);
        exp_t e;
        request   = 1'b1;
        x         = 11'(px);
        y         = 11'(py);
        TRIcolour = 4'(pc);
        if (keep) begin
            e.addr = 19'(py * HR + px);
            e.data = 4'(pc);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(idle === 1'b1 && mem_we === 1'b0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s idle_timeout after %0d cycles idle=%b", tag, n, idle);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (mem_we !== 1'b0)  begin errors++; $display("FAIL reset_we got %b want 0", mem_we); end
        if (mem_addr !== '0)  begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        if (mem_data !== '0)  begin errors++; $display("FAIL reset_data got %h want 0", mem_data); end
        if (dropped !== '0)   begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped); end
        if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got %b want 0", full); end
        if (idle !== 1'b1)    begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
        Reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        mem_ack = 1'b1;
        send(5, 2, 'hA, 1'b1);
        request = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL single_latency edge k+%0d we=%b want 0", j, mem_we);
            end
            @(posedge clk);
            #1;
        end
        checks += 3;
        if (mem_we !== 1'b1)   begin errors++; $display("FAIL single_we_k3 got %b want 1", mem_we); end
        if (mem_addr !== 19'd1285) begin errors++; $display("FAIL single_addr got %0d want 1285", mem_addr); end
        if (mem_data !== 4'hA) begin errors++; $display("FAIL single_data got %h want a", mem_data); end
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_k4 got %b want 0", mem_we); end
        wait_idle(20, "single");
    endtask

    task automatic test_clip();
        bit idle_drop = 1'b0;
        bit we_seen = 1'b0;
        int w0 = writes;
        mem_ack = 1'b1;
        send(HR, 0, 3, 1'b0);
        if (idle !== 1'b1) idle_drop = 1'b1;
        send(0, VR, 4, 1'b0);
        request = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (idle !== 1'b1) idle_drop = 1'b1;
            if (mem_we !== 1'b0) we_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks += 4;
        if (idle_drop)       begin errors++; $display("FAIL clip_idle got low want always 1"); end
        if (we_seen)         begin errors++; $display("FAIL clip_we got high want always 0"); end
        if (dropped !== '0)  begin errors++; $display("FAIL clip_dropped got %0d want 0", dropped); end
        if (writes != w0)    begin errors++; $display("FAIL clip_writes got %0d want 0", writes - w0); end
    endtask

    task automatic test_overflow();
        int w0 = writes;
        mem_ack = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send(i * 7, i + 1, (i % 15) + 1, i < 9);
        end
        request = 1'b0;
        checks += 2;
        if (full !== 1'b1)      begin errors++; $display("FAIL ovf_full got %b want 1", full); end
        if (dropped !== 16'd3)  begin errors++; $display("FAIL ovf_dropped got %0d want 3", dropped); end
        mem_ack = 1'b1;
        wait_idle(100, "overflow");
        checks += 2;
        if (writes - w0 != 9)   begin errors++; $display("FAIL ovf_writes got %0d want 9", writes - w0); end
        if (exp_q.size() != 0)  begin errors++; $display("FAIL ovf_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_ack_stall();
        int n = 0;
        logic [18:0] want_addr;
        want_addr = 19'(50 * HR + 100);
        mem_ack = 1'b0;
        send(100, 50, 5, 1'b1);
        request = 1'b0;
        while (mem_we !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 10) begin errors++; $display("FAIL stall_start we=%b want 1", mem_we); end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== want_addr || mem_data !== 4'h5) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got we=%b addr=%0d data=%h want 1 %0d 5",
                         j, mem_we, mem_addr, mem_data, want_addr);
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL stall_release we=%b want 0", mem_we); end
        wait_idle(20, "stall");
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int w0 = writes;
        wcycles.delete();
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(200 + i, 300 + i, i + 8, 1'b1);
        end
        request = 1'b0;
        wait_idle(60, "b2b");
        checks++;
        if (writes - w0 != 6) begin errors++; $display("FAIL b2b_writes got %0d want 6", writes - w0); end
        for (int i = 1; i < wcycles.size(); i++) begin
            checks++;
            if (wcycles[i] - wcycles[i-1] != 2) begin
                errors++;
                $display("FAIL b2b_spacing write %0d got %0d cycles want 2", i, wcycles[i] - wcycles[i-1]);
            end
        end
    endtask

    task automatic test_transparent();
        int cols[4] = '{0, 3, 0, 7};
        int w0 = writes;
        int want;
        bit keep;
`ifdef FB_TRANSPARENT_EN
        want = 2;
`else
        want = 4;
`endif
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef FB_TRANSPARENT_EN
            keep = (cols[i] != 0);
`else
            keep = 1'b1;
`endif
            send(10 + i, 20, cols[i], keep);
        end
        request = 1'b0;
        wait_idle(40, "transparent");
        checks++;
        if (writes - w0 != want) begin
            errors++;
            $display("FAIL transparent_writes got %0d want %0d", writes - w0, want);
        end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(30 + i, 40, i + 1, 1'b0);
        end
        request = 1'b0;
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL midrst_pre we=%b want 1", mem_we); end
        Reset = 1'b1;
        @(posedge clk);
        #1;
        checks += 4;
        if (mem_we !== 1'b0)  begin errors++; $display("FAIL midrst_we got %b want 0", mem_we); end
        if (idle !== 1'b1)    begin errors++; $display("FAIL midrst_idle got %b want 1", idle); end
        if (dropped !== '0)   begin errors++; $display("FAIL midrst_dropped got %0d want 0", dropped); end
        if (full !== 1'b0)    begin errors++; $display("FAIL midrst_full got %b want 0", full); end
        Reset = 1'b0;
        mem_ack = 1'b1;
        w0 = writes;
        repeat (15) @(posedge clk);
        #1;
        checks += 2;
        if (writes != w0)   begin errors++; $display("FAIL midrst_writes got %0d want 0", writes - w0); end
        if (idle !== 1'b1)  begin errors++; $display("FAIL midrst_idle_after got %b want 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_overflow();
        test_ack_stall();
        test_back_to_back();
        test_transparent();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
